// File: rtl/wb_regfile_if.sv
// Bus bundle between the execute/decode side and the write-back register file.
// Master drives results and read requests; slave returns reads and latch state.
interface wb_regfile_if #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
);
  logic                 stall_in;
  logic                 flush_in;
  logic                 rdE_in;
  logic [REG_IDX_W-1:0] rdIdx_in;
  logic [DATA_W-1:0]    rdData_in;
  logic                 re1_in;
  logic [REG_IDX_W-1:0] rs1Idx_in;
  logic [DATA_W-1:0]    rs1Data_out;
  logic                 re2_in;
  logic [REG_IDX_W-1:0] rs2Idx_in;
  logic [DATA_W-1:0]    rs2Data_out;
  logic                 wbE_out;
  logic [REG_IDX_W-1:0] wbIdx_out;
  logic [DATA_W-1:0]    wbData_out;

  modport master (
    output stall_in, flush_in,
    output rdE_in, rdIdx_in, rdData_in,
    output re1_in, rs1Idx_in,
    output re2_in, rs2Idx_in,
    input  rs1Data_out, rs2Data_out,
    input  wbE_out, wbIdx_out, wbData_out
  );

  modport slave (
    input  stall_in, flush_in,
    input  rdE_in, rdIdx_in, rdData_in,
    input  re1_in, rs1Idx_in,
    input  re2_in, rs2Idx_in,
    output rs1Data_out, rs2Data_out,
    output wbE_out, wbIdx_out, wbData_out
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch plus 32x32 integer register file, x0 tied to 0.
// Define REGFILE_BYPASS_EN to forward the pending write-back onto the read ports.
module wb_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int NUM_REGS  = 2**REG_IDX_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  wb_regfile_if.slave bus
);

  logic                 wb_e_q, wb_e_d;
  logic [REG_IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];

  logic                 commit;
  logic [DATA_W-1:0]    rs1_data, rs2_data;

  always_comb begin
    wb_e_d    = wb_e_q;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    if (bus.flush_in) begin
      wb_e_d    = 1'b0;
      wb_idx_d  = '0;
      wb_data_d = '0;
    end else if (!bus.stall_in) begin
      wb_e_d    = bus.rdE_in;
      wb_idx_d  = bus.rdIdx_in;
      wb_data_d = bus.rdData_in;
    end
  end

  // Commit is driven from the pre-edge latch, so a flush never cancels it.
  assign commit = wb_e_q && (wb_idx_q != '0);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wb_e_q    <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wb_e_q    <= wb_e_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
      if (commit) begin
        regs_q[wb_idx_q] <= wb_data_q;
      end
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rst_in && bus.re1_in && (bus.rs1Idx_in != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_e_q && (wb_idx_q == bus.rs1Idx_in)) begin
        rs1_data = wb_data_q;
      end else begin
        rs1_data = regs_q[bus.rs1Idx_in];
      end
`else
      rs1_data = regs_q[bus.rs1Idx_in];
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rst_in && bus.re2_in && (bus.rs2Idx_in != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_e_q && (wb_idx_q == bus.rs2Idx_in)) begin
        rs2_data = wb_data_q;
      end else begin
        rs2_data = regs_q[bus.rs2Idx_in];
      end
`else
      rs2_data = regs_q[bus.rs2Idx_in];
`endif
    end
  end

  assign bus.rs1Data_out = rs1_data;
  assign bus.rs2Data_out = rs2_data;
  assign bus.wbE_out     = wb_e_q;
  assign bus.wbIdx_out   = wb_idx_q;
  assign bus.wbData_out  = wb_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run against a behavioural model of the architectural state.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_regfile_if #(.DATA_W(32), .REG_IDX_W(5)) bus ();

  wb_regfile dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: register contents plus one pending result.
  logic [31:0] m_regs [32];
  logic        m_e;
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  function automatic logic [31:0] m_read(input logic re, input logic [4:0] idx);
    if (!rst_n || !re || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (m_e && m_idx == idx) return m_data;
`endif
    return m_regs[idx];
  endfunction

  // Apply one clock edge to the model from the currently driven inputs.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_e = 1'b0; m_idx = 5'd0; m_data = 32'd0;
    end else begin
      if (m_e && m_idx != 5'd0) m_regs[m_idx] = m_data;
      if (bus.flush_in) begin
        m_e = 1'b0; m_idx = 5'd0; m_data = 32'd0;
      end else if (!bus.stall_in) begin
        m_e = bus.rdE_in; m_idx = bus.rdIdx_in; m_data = bus.rdData_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_in  = 1'b0;
    bus.flush_in  = 1'b0;
    bus.rdE_in    = 1'b0;
    bus.rdIdx_in  = 5'd0;
    bus.rdData_in = 32'd0;
    bus.re1_in    = 1'b1;
    bus.re2_in    = 1'b1;
    bus.rs1Idx_in = 5'd0;
    bus.rs2Idx_in = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd3; bus.rdData_in = 32'hDEADBEEF;
    bus.rs1Idx_in = 5'd3;
    tick(); tick();
    checks++;
    if (bus.wbE_out !== 1'b0 || bus.wbIdx_out !== 5'd0 || bus.wbData_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_latch: got e=%b idx=%0d data=%h, want 0/0/0",
               bus.wbE_out, bus.wbIdx_out, bus.wbData_out);
    end
    checks++;
    if (bus.rs1Data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_rs1: got %h, want 0", bus.rs1Data_out);
    end
    rst_n = 1'b1;
    idle();
    tick();
    for (int i = 1; i < 32; i++) begin
      bus.rs1Idx_in = 5'(i);
      bus.rs2Idx_in = 5'(31 - i + 1);
      #1;
      checks++;
      if (bus.rs1Data_out !== 32'd0 || bus.rs2Data_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_regs x%0d: got %h/%h, want 0", i,
                 bus.rs1Data_out, bus.rs2Data_out);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_early;
    idle();
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd5; bus.rdData_in = 32'h12345678;
    tick();
    bus.rdE_in = 1'b0;
    bus.rs1Idx_in = 5'd5;
    #1;
    checks++;
    if (bus.wbE_out !== 1'b1 || bus.wbIdx_out !== 5'd5 || bus.wbData_out !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_latch: got e=%b idx=%0d data=%h, want 1/5/12345678",
               bus.wbE_out, bus.wbIdx_out, bus.wbData_out);
    end
`ifdef REGFILE_BYPASS_EN
    exp_early = 32'h12345678;
`else
    exp_early = 32'd0;
`endif
    checks++;
    if (bus.rs1Data_out !== exp_early) begin
      errors++;
      $display("FAIL basic_early_read: got %h, want %h", bus.rs1Data_out, exp_early);
    end
    tick();
    tick();
    checks++;
    if (bus.rs1Data_out !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_read: got %h, want 12345678", bus.rs1Data_out);
    end
  endtask

  task automatic test_x0();
    idle();
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd0; bus.rdData_in = 32'hFFFFFFFF;
    tick();
    bus.rdE_in = 1'b0;
    #1;
    checks++;
    if (bus.wbE_out !== 1'b1 || bus.wbIdx_out !== 5'd0) begin
      errors++;
      $display("FAIL x0_latch: got e=%b idx=%0d, want 1/0", bus.wbE_out, bus.wbIdx_out);
    end
    tick();
    bus.rs1Idx_in = 5'd0;
    #1;
    checks++;
    if (bus.rs1Data_out !== 32'd0) begin
      errors++;
      $display("FAIL x0_read: got %h, want 0", bus.rs1Data_out);
    end
    for (int i = 1; i < 32; i++) begin
      bus.rs2Idx_in = 5'(i);
      #1;
      checks++;
      if (bus.rs2Data_out !== ((i == 5) ? 32'h12345678 : 32'd0)) begin
        errors++;
        $display("FAIL x0_others x%0d: got %h, want %h", i, bus.rs2Data_out,
                 (i == 5) ? 32'h12345678 : 32'd0);
      end
      tick();
    end
  endtask

  task automatic test_stall_flush();
    idle();
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd7; bus.rdData_in = 32'hA5A5A5A5;
    tick();
    bus.stall_in = 1'b1;
    bus.rdIdx_in = 5'd8; bus.rdData_in = 32'h0BADF00D;
    bus.rs1Idx_in = 5'd8;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.wbE_out !== 1'b1 || bus.wbIdx_out !== 5'd7 || bus.wbData_out !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL stall_hold c%0d: got e=%b idx=%0d data=%h, want 1/7/a5a5a5a5",
                 c, bus.wbE_out, bus.wbIdx_out, bus.wbData_out);
      end
      checks++;
      if (bus.rs1Data_out !== 32'd0) begin
        errors++;
        $display("FAIL stall_x8 c%0d: got %h, want 0", c, bus.rs1Data_out);
      end
    end
    bus.flush_in = 1'b1;
    tick();
    checks++;
    if (bus.wbE_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got e=%b, want 0", bus.wbE_out);
    end
    idle();
    bus.rs1Idx_in = 5'd7; bus.rs2Idx_in = 5'd8;
    #1;
    checks++;
    if (bus.rs1Data_out !== 32'hA5A5A5A5 || bus.rs2Data_out !== 32'd0) begin
      errors++;
      $display("FAIL flush_regs: got x7=%h x8=%h, want a5a5a5a5/0",
               bus.rs1Data_out, bus.rs2Data_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd9; bus.rdData_in = 32'h11;
    tick();
    bus.rdData_in = 32'h22;
    tick();
    bus.rdE_in = 1'b0;
    tick(); tick();
    bus.re1_in = 1'b0; bus.rs1Idx_in = 5'd9;
    bus.re2_in = 1'b1; bus.rs2Idx_in = 5'd9;
    #1;
    checks++;
    if (bus.rs1Data_out !== 32'd0) begin
      errors++;
      $display("FAIL re1_off: got %h, want 0", bus.rs1Data_out);
    end
    checks++;
    if (bus.rs2Data_out !== 32'h22) begin
      errors++;
      $display("FAIL order_x9: got %h, want 22", bus.rs2Data_out);
    end
    bus.re1_in = 1'b1;
    #1;
    checks++;
    if (bus.rs1Data_out !== bus.rs2Data_out || bus.rs1Data_out !== 32'h22) begin
      errors++;
      $display("FAIL same_idx: got %h/%h, want 22/22", bus.rs1Data_out, bus.rs2Data_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.rdE_in = 1'b1; bus.rdIdx_in = 5'd4; bus.rdData_in = 32'h55;
    tick();
    bus.rdE_in = 1'b0;
    rst_n = 1'b0;
    bus.rs1Idx_in = 5'd9;
    #1;
    checks++;
    if (bus.rs1Data_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_force: got %h, want 0", bus.rs1Data_out);
    end
    tick();
    checks++;
    if (bus.wbE_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_latch: got e=%b, want 0", bus.wbE_out);
    end
    rst_n = 1'b1;
    bus.rs1Idx_in = 5'd4; bus.rs2Idx_in = 5'd9;
    #1;
    checks++;
    if (bus.rs1Data_out !== 32'd0 || bus.rs2Data_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_regs: got x4=%h x9=%h, want 0/0",
               bus.rs1Data_out, bus.rs2Data_out);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int c = 0; c < 400; c++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      bus.stall_in  = ($urandom_range(0, 4) == 0);
      bus.flush_in  = ($urandom_range(0, 7) == 0);
      bus.rdE_in    = ($urandom_range(0, 1) == 1);
      bus.rdIdx_in  = 5'($urandom_range(0, 7));
      bus.rdData_in = $urandom;
      bus.re1_in    = ($urandom_range(0, 5) != 0);
      bus.re2_in    = ($urandom_range(0, 5) != 0);
      bus.rs1Idx_in = 5'($urandom_range(0, 7));
      bus.rs2Idx_in = 5'($urandom_range(0, 7));
      #1;
      e1 = m_read(bus.re1_in, bus.rs1Idx_in);
      e2 = m_read(bus.re2_in, bus.rs2Idx_in);
      checks++;
      if (bus.rs1Data_out !== e1 || bus.rs2Data_out !== e2) begin
        errors++;
        $display("FAIL rand_read c%0d: got %h/%h, want %h/%h", c,
                 bus.rs1Data_out, bus.rs2Data_out, e1, e2);
      end
      tick();
      checks++;
      if (bus.wbE_out !== m_e ||
          (m_e && (bus.wbIdx_out !== m_idx || bus.wbData_out !== m_data))) begin
        errors++;
        $display("FAIL rand_latch c%0d: got e=%b idx=%0d data=%h, want %b/%0d/%h", c,
                 bus.wbE_out, bus.wbIdx_out, bus.wbData_out, m_e, m_idx, m_data);
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_e = 1'b0; m_idx = 5'd0; m_data = 32'd0;
    idle();
    test_reset();
    test_basic();
    test_x0();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus integer register file. Consumes the destination-register result stream (rdE, rdIdx, rdData) produced by the execute path.
- Latches each result for one cycle in a MEM/WB latch, then commits it to 32 x 32-bit architectural registers.
- Serves two combinational read ports to the decode stage. x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register/data width
- REG_IDX_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**REG_IDX_W)

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  synchronous, active-low reset
- stall_in  input  1  hold MEM/WB latch contents
- flush_in  input  1  discard the result being captured this edge
- rdE_in  input  1  result write enable from execute path
- rdIdx_in  input  REG_IDX_W  destination register index
- rdData_in  input  DATA_W  result data
- re1_in  input  1  read port 1 enable
- rs1Idx_in  input  REG_IDX_W  read port 1 index
- rs1Data_out  output  DATA_W  read port 1 data
- re2_in  input  1  read port 2 enable
- rs2Idx_in  input  REG_IDX_W  read port 2 index
- rs2Data_out  output  DATA_W  read port 2 data
- wbE_out  output  1  latched write enable (commit pending)
- wbIdx_out  output  REG_IDX_W  latched destination index
- wbData_out  output  DATA_W  latched data

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-low. Everything below is sampled on the rising edge of clk_in.
- Reset (rst_in=0 at edge):
  - wbE_out=0, wbIdx_out=0, wbData_out=0.
  - All NUM_REGS registers cleared to 0.
  - While rst_in=0, rs1Data_out and rs2Data_out are forced to 0.
  - Reset overrides stall_in and flush_in.
- MEM/WB latch update, in priority order:
  - flush_in=1: wbE_out<=0; wbIdx_out and wbData_out don't-care (implementation clears them to 0).
  - else stall_in=1: hold all three latch outputs.
  - else: capture rdE_in, rdIdx_in, rdData_in.
  - flush beats stall when both are asserted.
- Commit:
  - At each edge with rst_in=1, wbE_out=1 and wbIdx_out!=0: regs[wbIdx_out]<=wbData_out. This uses the pre-edge latch value.
  - Latency: a result presented at edge N is latched at N and written to the register array at N+1.
  - Flush at edge N+1 does not cancel the commit at N+1. Flush only drops the entry being captured.
  - During stall the latched write re-commits every edge. This is idempotent and required.
- x0:
  - Writes with index 0 are latched (wbE_out may be 1) but never modify the array.
  - Reads of index 0 always return 0.
- Read ports, purely combinational, evaluated per port in priority order:
  1. rst_in=0 -> 0.
  2. re=0 -> 0.
  3. idx=0 -> 0.
  4. Bypass hit (see Optional Feature) -> wbData_out.
  5. Otherwise regs[idx].
- Same-index reads on both ports return identical data.
- Back-to-back writes to the same register: each commits in order. The final value is the later result.
- Out-of-range behaviour: none. All REG_IDX_W index values are valid.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read with re=1, idx!=0, wbE_out=1 and wbIdx_out==idx returns wbData_out. Decode sees the pending write-back value in the same cycle it sits in the latch (write-before-read semantics).
- Undefined: reads return only the array contents. A read in the same cycle as a pending commit returns the old value; the new value is visible from the cycle after commit. The hazard must be handled by upstream stalling.
- The macro affects only the read-path mux. Latch and commit timing are identical in both builds.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with rdE_in=1, rdIdx_in=3, rdData_in=0xDEADBEEF -> wbE_out=0, all regs 0, rs1Data_out=0 with re1_in=1, rs1Idx_in=3.
- Basic write/read:
  - Stimulus: rdE_in=1, rdIdx_in=5, rdData_in=0x12345678 at edge N, then rdE_in=0.
  - wbE_out=1 after edge N.
  - At N+2, rs1Idx_in=5 reads 0x12345678.
  - With REGFILE_BYPASS_EN, rs1 reads 0x12345678 already in the cycle after N. Without it, that cycle reads 0.
- x0 protection: write rdIdx_in=0, rdData_in=0xFFFFFFFF -> wbE_out=1, later read of idx 0 returns 0, all other regs unchanged.
- Stall and flush:
  - Latch idx 7 = 0xA5A5A5A5, then assert stall_in for 3 cycles while rdIdx_in=8 -> wbIdx_out stays 7, reg 8 stays 0.
  - Assert flush_in and stall_in together -> wbE_out=0 next cycle, reg 7 = 0xA5A5A5A5.
- Ordering and port independence:
  - Write x9=0x11, then x9=0x22 on consecutive edges -> final read 0x22.
  - re1_in=0, rs1Idx_in=9 -> rs1Data_out=0.
  - re2_in=1, rs2Idx_in=9 -> rs2Data_out=0x22.
- Reset mid-operation: latch idx 4 = 0x55, assert rst_in=0 at the commit edge -> reg 4 stays 0, wbE_out=0.
